// File: rtl/spi_regfile.sv
// SPI mode-0 register bank: oversampled write/read-back of NUM_REGS x DATA_W config registers.
// Frame on the wire, MSB first: R/W (1=write), ADDR_W address bits, DATA_W data bits.
module spi_regfile #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ncs,
  input  logic                       sclk,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  C_ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  C_RD_SHIFT  = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0]  C_FRAME     = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  C_SAT       = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]   C_NREGS     = (ADDR_W+1)'(NUM_REGS);

  logic [2:0]                       r_ncs_s, r_sclk_s;
  logic [1:0]                       r_copi_s;
  logic                             r_warm, r_ncs_armed, r_active, r_rd;
  logic [CNT_W-1:0]                 r_cnt;
  logic [FRAME_W-1:0]               r_shift;
  logic [DATA_W-1:0]                r_rd_sh;
  logic [NUM_REGS-1:0][DATA_W-1:0]  r_regs;
  logic                             r_wr_pulse, r_frame_err;
  logic [ADDR_W-1:0]                r_wr_addr;

  logic              w_ncs_fall, w_ncs_rise, w_sclk_rise, w_sclk_fall, w_copi, w_live;
  logic [ADDR_W-1:0] w_rd_addr, w_fr_addr;
  logic [DATA_W-1:0] w_rd_data, w_fr_data;
  logic              w_rd_req, w_fr_rw, w_fr_ok, w_addr_ok, w_commit, w_bad;

  // A falling edge only counts once ncs has been seen high on the real pin after
  // reset, so a frame held low across reset release is ignored entirely.
  assign w_ncs_fall  = r_ncs_s[2] & ~r_ncs_s[1] & r_ncs_armed;
  assign w_ncs_rise  = ~r_ncs_s[2] & r_ncs_s[1];
  assign w_sclk_rise = ~r_sclk_s[2] & r_sclk_s[1];
  assign w_sclk_fall = r_sclk_s[2] & ~r_sclk_s[1];
  assign w_copi      = r_copi_s[1];
  assign w_live      = r_active & ~r_ncs_s[1];

  // Read decision is taken on the edge that samples the last address bit.
  assign w_rd_addr = {r_shift[ADDR_W-2:0], w_copi};
  assign w_rd_req  = w_live & w_sclk_rise & (r_cnt == C_ADDR_LAST) & ~r_shift[ADDR_W-1];

  assign w_fr_rw   = r_shift[FRAME_W-1];
  assign w_fr_addr = r_shift[DATA_W +: ADDR_W];
  assign w_fr_data = r_shift[DATA_W-1:0];
  assign w_fr_ok   = (r_cnt == C_FRAME);
  assign w_addr_ok = ({1'b0, w_fr_addr} < C_NREGS);
  assign w_commit  = r_active & w_ncs_rise & w_fr_ok & w_fr_rw & w_addr_ok;
  assign w_bad     = r_active & w_ncs_rise & ~w_fr_ok;

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (w_rd_addr == ADDR_W'(k)) w_rd_data = r_regs[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ncs_s     <= 3'b111;
      r_sclk_s    <= 3'b000;
      r_copi_s    <= 2'b00;
      r_warm      <= 1'b0;
      r_ncs_armed <= 1'b0;
      r_active    <= 1'b0;
      r_rd        <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rd_sh     <= '0;
      r_regs      <= '0;
      r_wr_pulse  <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= '0;
    end else begin
      r_ncs_s    <= {r_ncs_s[1:0], ncs};
      r_sclk_s   <= {r_sclk_s[1:0], sclk};
      r_copi_s   <= {r_copi_s[0], copi};
      r_warm     <= 1'b1;
      if (r_warm && r_ncs_s[0]) r_ncs_armed <= 1'b1;
      r_wr_pulse  <= w_commit;
      r_frame_err <= w_bad;

      if (w_ncs_fall) begin
        r_active <= 1'b1;
        r_cnt    <= '0;
        r_shift  <= '0;
        r_rd     <= 1'b0;
      end else if (w_ncs_rise) begin
        r_active <= 1'b0;
        r_rd     <= 1'b0;
      end else if (w_live) begin
        if (w_sclk_rise) begin
          r_shift <= {r_shift[FRAME_W-2:0], w_copi};
          if (r_cnt != C_SAT) r_cnt <= r_cnt + 1'b1;
          if (w_rd_req) begin
            r_rd    <= 1'b1;
            r_rd_sh <= w_rd_data;
          end
        end
        // First data bit is held across the falling edge right after the address.
        if (w_sclk_fall && (r_cnt > C_RD_SHIFT)) r_rd_sh <= r_rd_sh << 1;
      end

      if (w_commit) r_wr_addr <= w_fr_addr;
      for (int k = 0; k < NUM_REGS; k++)
        if (w_commit && (w_fr_addr == ADDR_W'(k))) r_regs[k] <= w_fr_data;
    end
  end

  assign cipo      = r_rd & r_rd_sh[DATA_W-1];
  assign cipo_oe   = r_rd;
  assign regs_out  = r_regs;
  assign wr_pulse  = r_wr_pulse;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_frame_err;

endmodule

// File: doc/spi_regfile.md
# spi_regfile

Parametrised SPI (mode 0) peripheral that exposes a bank of `NUM_REGS` configuration registers of `DATA_W` bits to an external SPI controller, with both write and read-back. It sits between the chip's SPI pins and the on-chip consumers of configuration (output enables, PWM enables, duty cycles, ...), which read the registers from a flat parallel bus. All SPI pins are asynchronous to `clk`; the block synchronises and oversamples them.

## Interface
Parameters:
- `NUM_REGS`, 5: number of registers; valid addresses 0..NUM_REGS-1.
- `DATA_W`, 8: register width in bits.
- `ADDR_W`, 7: address field width; NUM_REGS ≤ 2^ADDR_W.
- Derived `FRAME_W` = 1 + ADDR_W + DATA_W (16 with defaults).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ncs`  in  1  SPI chip select, active low, async.
- `sclk`  in  1  SPI clock, async.
- `copi`  in  1  SPI data from controller, async.
- `cipo`  out  1  SPI data to controller.
- `cipo_oe`  out  1  output enable for `cipo` pad.
- `regs_out`  out  NUM_REGS*DATA_W  register bank; reg k at bits [k*DATA_W +: DATA_W].
- `wr_pulse`  out  1  one-cycle strobe on a committed write.
- `wr_addr`  out  ADDR_W  address of last committed write.
- `frame_err`  out  1  one-cycle strobe on a malformed frame.

## Operation
- Synchronisers: `ncs`, `sclk`, `copi` each pass through 2 flops; a third stage on `ncs` and `sclk` gives edge detection. Sync reset values: ncs=1, sclk=0, copi=0.
- Frame, MSB first: bit 0 on wire = R/W (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits.
- Frame start: synchronised ncs falling edge clears bit counter (`ADDR_W+DATA_W+1`-range, saturating at FRAME_W+1), shift register, and read flag.
- While synchronised ncs low, each sclk rising edge samples synchronised copi into the shift register and increments the counter. sclk edges while ncs high are ignored.
- Read: when the counter reaches 1+ADDR_W with R/W=0, load the read shifter with the addressed register (0 if address ≥ NUM_REGS). `cipo` = read shifter MSB. On sclk falling edges, shift left only while counter > 1+ADDR_W (so the first data bit is held across the falling edge after the last address bit). `cipo_oe`=1 from load until ncs rising edge; otherwise `cipo`=0, `cipo_oe`=0.
- Frame end (synchronised ncs rising edge):
  - counter == FRAME_W, write, address < NUM_REGS: update register, `wr_pulse`=1, `wr_addr` = address.
  - counter == FRAME_W, address ≥ NUM_REGS: no update, no strobes.
  - counter == FRAME_W, read: no update, no strobes.
  - counter ≠ FRAME_W (short or over-length, including 0 bits): no update, `frame_err`=1.
- Reset: all registers, `wr_addr`, strobes, `cipo`, `cipo_oe` = 0; counter = 0; frame in progress discarded. If ncs is held low across reset deassertion, no falling edge is seen and that frame is ignored entirely (no commit, no `frame_err` on its rising edge, since no frame is active).
- A new ncs falling edge in the same cycle as a commit is impossible (≥2-cycle separation via synchronisers); back-to-back frames are fully independent.

## Timing
- Pin-to-detect latency: 3 `clk` cycles for any sclk/ncs edge.
- Requirement: sclk high and low phases ≥ 4 `clk` periods each; ncs high between frames ≥ 4 `clk` periods.
- Write commit: register, `wr_pulse`, `wr_addr` all update on the same `clk` edge, 3 cycles after ncs pin rises; `wr_pulse` high for exactly 1 cycle.
- `frame_err` likewise asserted 1 cycle, same relative timing.
- `cipo` valid ≤ 4 `clk` cycles after the sclk falling edge that shifts it (or after the last address rising edge, for the first data bit).

## Test plan
- Write 0x82A5 (write, addr 2, data 0xA5) -> reg 2 = 0xA5, `wr_pulse` 1 cycle, `wr_addr`=2; other regs unchanged.
- After the above, read frame 0x0200 -> `cipo` shifts out 1010_0101 on the 8 data bits, `cipo_oe`=1 during data phase, regs unchanged, no strobes.
- Write 0x89FF (addr 9 ≥ NUM_REGS) -> no register change, no `wr_pulse`, no `frame_err`; read of addr 9 returns 0x00.
- Write frame aborted after 10 sclk (and one with 17 sclk) -> no register change, `frame_err` 1 cycle each.
- Assert `rst` mid-frame after 8 bits of 0x84FF, release with ncs still low, finish clocking -> all regs 0, no commit, no strobes; next clean frame 0x8433 -> reg 4 = 0x33.
- Back-to-back writes 0x8011, 0x8122 with minimum ncs gap -> reg0=0x11, reg1=0x22, two separate `wr_pulse`.
